// File: rtl/lfsr4_checker.sv
// ---------------------------------------------------------------------------
// lfsr4_checker
//
// Monitors the output of the 4-bit maximal-length LFSR pattern source
// (x^4 + x^3 + 1). The block locks onto the incoming words and predicts each
// next word. It flags and counts words that do not match the prediction, and
// it marks the start of every sequence period.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - synchronous reset, active-high, overrides every other input
//   in_valid   - in_data carries a new LFSR word this cycle
//   in_data    - LFSR word, bit 3 is the MSB
//   clr_err    - synchronous clear of err_count (wins over an increment)
//   locked     - registered, high while the checker is locked to the source
//   err        - registered one-cycle pulse per mispredicted word while locked
//   err_count  - saturating count of err pulses
//   seq_start  - registered one-cycle pulse when a correctly predicted word
//                equals SEED while locked
// ---------------------------------------------------------------------------
module lfsr4_checker #(
  parameter int         LOCK_CNT   = 4,
  parameter int         UNLOCK_CNT = 3,
  parameter int         CNT_W      = 8,
  parameter logic [3:0] SEED       = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             seq_start
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         exp_q, exp_d;
  logic [MATCH_W-1:0] match_q, match_d, match_inc;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               seq_start_q, seq_start_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  // One step of the source LFSR: shift left, feed back x[3] ^ x[2].
  function automatic logic [3:0] nxt(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  // Next-state logic for the lock FSM, the prediction register, and the
  // match/miss counters. Cycles without in_valid leave everything as it is,
  // so gaps in the source never count toward lock or unlock. An all-zero word
  // cannot occur in a healthy sequence, so SEARCH ignores it and VERIFY
  // treats it as a lost source and falls back to SEARCH. In LOCKED the
  // prediction always advances, even on a miss. An isolated corrupt word
  // therefore costs exactly one error instead of derailing the following
  // words.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = 1'b0;
    seq_start_d = 1'b0;
    match_inc   = match_q + MATCH_W'(1);
    miss_inc    = miss_q + MISS_W'(1);

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (in_data != 4'b0000) begin
            exp_d   = nxt(in_data);
            match_d = '0;
            state_d = VERIFY;
          end
        end

        VERIFY: begin
          if (in_data == exp_q) begin
            exp_d = nxt(exp_q);
            if (match_inc == MATCH_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else if (in_data == 4'b0000) begin
            state_d = SEARCH;
            match_d = '0;
          end else begin
            exp_d   = nxt(in_data);
            match_d = '0;
          end
        end

        LOCKED: begin
          exp_d = nxt(exp_q);
          if (in_data == exp_q) begin
            miss_d      = '0;
            seq_start_d = (in_data == SEED);
          end else begin
            err_d = 1'b1;
            if (miss_inc == MISS_W'(UNLOCK_CNT)) begin
              state_d = SEARCH;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // Error counter: clr_err beats a same-cycle increment. The count sticks at
  // all-ones rather than wrapping, so a long failure never reads back as a
  // small number.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = '0;
    end else if (err_d && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // All state and all outputs live in this one register block. Reset
  // returns the checker to SEARCH with a clean prediction and clean
  // counters, whatever it was doing before.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      exp_q       <= 4'b0000;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      seq_start_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      seq_start_q <= seq_start_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign seq_start = seq_start_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr4_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr4_checker
//
// Directed testbench for lfsr4_checker. It drives two instances from the same
// inputs. The first uses the default 8-bit error counter. The second uses a
// 4-bit counter so that saturation can be reached. The expected LFSR words
// come from a hand-written table of the 15-word period.
// ---------------------------------------------------------------------------
module tb_lfsr4_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       clr_err;

  logic       locked, err, seq_start;
  logic [7:0] err_count;
  logic       locked4, err4, seq_start4;
  logic [3:0] err_count4;

  logic [3:0] seq [15];
  int         checks;
  int         errors;
  int         pos;
  int         pulses;

  lfsr4_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_err   (clr_err),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .seq_start (seq_start)
  );

  lfsr4_checker #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_err   (clr_err),
    .locked    (locked4),
    .err       (err4),
    .err_count (err_count4),
    .seq_start (seq_start4)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Present one input word, step past the rising edge, and settle 1 ns so
  // that the outputs seen afterwards reflect the word just consumed.
  task automatic applyStimulus(input logic v, input logic [3:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed scenario, applied in order.
  initial begin
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
            4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
            4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    clk      = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'b0000;
    clr_err  = 1'b0;
    checks   = 0;
    errors   = 0;
    pos      = 0;
    pulses   = 0;

    // Reset state.
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_count", err_count, 0);
    checkOutput("rst_seq_start", seq_start, 0);
    rst = 1'b0;

    // Acquire lock: capture on 0001, then four correct predictions.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, seq[pos % 15]);
      pos++;
      checkOutput("acq_locked", locked, (i == 4) ? 8'd1 : 8'd0);
      checkOutput("acq_seq_start", seq_start, 0);
    end

    // 45 further clean words: no errors, seq_start only on 0001.
    for (int i = 0; i < 45; i++) begin
      applyStimulus(1'b1, seq[pos % 15]);
      checkOutput("run_err", err, 0);
      checkOutput("run_locked", locked, 1);
      checkOutput("run_seq_start", seq_start,
                  (seq[pos % 15] == 4'b0001) ? 8'd1 : 8'd0);
      if (seq_start) pulses++;
      pos++;
    end
    checkOutput("run_pulses", pulses[7:0], 3);

    // A single corrupt word (1111 in place of 1101).
    applyStimulus(1'b1, seq[pos % 15]);
    pos++;
    applyStimulus(1'b1, 4'b1111);
    pos++;
    checkOutput("single_err", err, 1);
    checkOutput("single_count", err_count, 1);
    checkOutput("single_locked", locked, 1);
    clr_err = 1'b1;
    applyStimulus(1'b1, seq[pos % 15]);
    pos++;
    clr_err = 1'b0;
    checkOutput("after_single_err", err, 0);
    checkOutput("after_single_locked", locked, 1);
    checkOutput("clr_count", err_count, 0);

    // Three consecutive wrong words force a loss of lock.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, seq[pos % 15] ^ 4'b0011);
      pos++;
      checkOutput("burst_err", err, 1);
      checkOutput("burst_count", err_count, 8'(i + 1));
      checkOutput("burst_locked", locked, (i == 2) ? 8'd0 : 8'd1);
    end

    // Resynchronise: one capture plus four correct words.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, seq[pos % 15]);
      pos++;
      checkOutput("resync_err", err, 0);
      checkOutput("resync_locked", locked, (i == 4) ? 8'd1 : 8'd0);
    end

    // Free-running source with gaps. Gap cycles carry garbage data.
    for (int i = 0; i < 30; i++) begin
      if ((i % 3) == 1) begin
        applyStimulus(1'b0, 4'b1010);
        checkOutput("gap_seq_start", seq_start, 0);
      end else begin
        applyStimulus(1'b1, seq[pos % 15]);
        checkOutput("gapped_seq_start", seq_start,
                    (seq[pos % 15] == 4'b0001) ? 8'd1 : 8'd0);
        pos++;
      end
      checkOutput("gapped_err", err, 0);
      checkOutput("gapped_locked", locked, 1);
    end
    checkOutput("gapped_count", err_count, 3);

    // clr_err during a gap clears the count without touching lock.
    clr_err = 1'b1;
    applyStimulus(1'b0, 4'b0000);
    clr_err = 1'b0;
    checkOutput("gap_clr_count", err_count, 0);
    checkOutput("gap_clr_locked", locked, 1);

    // Five isolated errors bring the count to 5.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, seq[pos % 15] ^ 4'b0100);
      pos++;
      applyStimulus(1'b1, seq[pos % 15]);
      pos++;
    end
    checkOutput("five_count", err_count, 5);
    checkOutput("five_locked", locked, 1);

    // Reset mid-lock, with a wrong word present on the input at the same time.
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0101);
    rst = 1'b0;
    checkOutput("midrst_locked", locked, 0);
    checkOutput("midrst_count", err_count, 0);
    checkOutput("midrst_err", err, 0);

    // Relock with a gap before every valid word: lock counts valid words only.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput("relock_gap_locked", locked, 0);
      applyStimulus(1'b1, seq[pos % 15]);
      pos++;
      checkOutput("relock_locked", locked, (i == 4) ? 8'd1 : 8'd0);
    end

    // clr_err in the same cycle as an error: err pulses and the count is 0.
    clr_err = 1'b1;
    applyStimulus(1'b1, seq[pos % 15] ^ 4'b1000);
    pos++;
    clr_err = 1'b0;
    checkOutput("clr_same_err", err, 1);
    checkOutput("clr_same_count", err_count, 0);
    checkOutput("clr_same_count4", err_count4, 0);
    applyStimulus(1'b1, seq[pos % 15]);
    pos++;
    checkOutput("clr_same_after_err", err, 0);
    checkOutput("clr_same_after_locked", locked, 1);

    // Two misses then one hit, eight times: 16 errors without losing lock.
    for (int g = 0; g < 8; g++) begin
      applyStimulus(1'b1, seq[pos % 15] ^ 4'b0001);
      pos++;
      applyStimulus(1'b1, seq[pos % 15] ^ 4'b0010);
      pos++;
      applyStimulus(1'b1, seq[pos % 15]);
      pos++;
      if (g == 6) checkOutput("sat_count4_14", err_count4, 14);
    end
    checkOutput("sat_count4", err_count4, 15);
    checkOutput("sat_count8", err_count, 16);
    checkOutput("sat_locked", locked, 1);
    checkOutput("sat_locked4", locked4, 1);

    // A stuck-at-0000 input after reset never leaves SEARCH.
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 4'b0000);
      checkOutput("stuck_locked", locked, 0);
      checkOutput("stuck_err", err, 0);
    end
    checkOutput("stuck_count", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
